// File: rtl/rx_chan_packer_pkg.sv
// rx_chan_packer_pkg: shared sizes, state encoding and header layout for the RX channel packer.
// RX_PACKER_HEADER_EN adds one header word to every frame.
package rx_chan_packer_pkg;
   localparam int NCHAN      = 4;
   localparam int WIDTH      = 16;
   localparam int DEPTH      = 1024;
   localparam int USEDW_BITS = 10;
   localparam int LEN_BITS   = USEDW_BITS + 1;
`ifdef RX_PACKER_HEADER_EN
   localparam int HDR_WORDS  = 1;
`else
   localparam int HDR_WORDS  = 0;
`endif
   localparam int IDX_BITS    = $clog2(2*NCHAN + HDR_WORDS);
   localparam int HDR_SEQ_MSB = 15;
   localparam int HDR_SEQ_LSB = 8;
   localparam int HDR_OVR     = 7;
   localparam int HDR_NCH_MSB = 2;
   localparam int HDR_NCH_LSB = 0;
   localparam logic [15:0] OVR_CNT_MAX = 16'hFFFF;

   typedef enum logic {ST_IDLE, ST_WRITE} state_t;

   function automatic logic [2:0] clamp_nch(input logic [2:0] c);
      return (c > 3'(NCHAN)) ? 3'(NCHAN) : c;
   endfunction

   function automatic logic [LEN_BITS-1:0] frame_len(input logic [2:0] nch);
      return LEN_BITS'({nch, 1'b0}) + LEN_BITS'(HDR_WORDS);
   endfunction

   function automatic logic [WIDTH-1:0] make_header(input logic [7:0] seq, input logic ovr,
                                                    input logic [2:0] nch);
      logic [WIDTH-1:0] h;
      h = '0;
      h[HDR_SEQ_MSB:HDR_SEQ_LSB] = seq;
      h[HDR_OVR] = ovr;
      h[HDR_NCH_MSB:HDR_NCH_LSB] = nch;
      return h;
   endfunction
endpackage

// File: rtl/rx_chan_packer_word_sel.sv
// rx_word_sel: picks the FIFO word for the current frame index from the latched sample set.
// With RX_PACKER_HEADER_EN, index 0 is the header and samples shift up by one.
module rx_word_sel
   import rx_chan_packer_pkg::*;
(
   input  logic [2*NCHAN*WIDTH-1:0] samples,
`ifdef RX_PACKER_HEADER_EN
   input  logic [WIDTH-1:0]         header,
`endif
   input  logic [IDX_BITS-1:0]      idx,
   output logic [WIDTH-1:0]         word
);
   logic [WIDTH-1:0] words [2*NCHAN];

   for (genvar i = 0; i < 2*NCHAN; i++) begin : g_w
      assign words[i] = samples[i*WIDTH +: WIDTH];
   end

`ifdef RX_PACKER_HEADER_EN
   logic [2:0] sel;
   assign sel  = 3'(idx - IDX_BITS'(1));
   assign word = (idx == '0) ? header : words[sel];
`else
   assign word = words[idx];
`endif
endmodule

// File: rtl/rx_chan_packer.sv
// rx_chan_packer: writes one I/Q pair per active channel into the RX FIFO per strobe, whole frames only.
// Define RX_PACKER_HEADER_EN to prefix each frame with a {seq, overrun, nch} header word.
module rx_chan_packer
   import rx_chan_packer_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic [2:0]               channels,
   input  logic                     strobe,
   input  logic [2*NCHAN*WIDTH-1:0] sample_bus,
   input  logic [USEDW_BITS-1:0]    fifo_wrusedw,
   input  logic                     fifo_wrfull,
   output logic [WIDTH-1:0]         fifo_data,
   output logic                     fifo_wrreq,
   output logic                     busy,
   output logic                     overrun,
   output logic [15:0]              overrun_count
);
   state_t                   state, state_nx;
   logic [2*NCHAN*WIDTH-1:0] samples;
   logic [2:0]               nch_in, nch_q;
   logic [IDX_BITS-1:0]      idx;
   logic [LEN_BITS-1:0]      flen_in, flen_q, free;
   logic                     fits, accept, drop, abort, last;
   logic [WIDTH-1:0]         word;

   assign nch_in     = clamp_nch(channels);
   assign flen_in    = frame_len(nch_in);
   assign flen_q     = frame_len(nch_q);
   assign free       = fifo_wrfull ? '0 : LEN_BITS'(DEPTH) - {1'b0, fifo_wrusedw};
   assign fits       = free >= flen_in;
   assign busy       = state == ST_WRITE;
   assign abort      = busy && fifo_wrfull;
   assign last       = busy && LEN_BITS'(idx) == flen_q - LEN_BITS'(1);
   assign accept     = strobe && nch_in != '0 && !busy && fits;
   // A strobe while writing, even on the last word, loses its frame.
   assign drop       = abort || (strobe && nch_in != '0 && (busy || !fits));
   assign fifo_wrreq = busy && !fifo_wrfull;
   assign fifo_data  = busy ? word : '0;

   always_comb begin
      state_nx = busy ? ((abort || last) ? ST_IDLE : ST_WRITE) : (accept ? ST_WRITE : ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= clear ? ST_IDLE : state_nx;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         samples       <= '0;
         nch_q         <= '0;
         idx           <= '0;
         overrun       <= 1'b0;
         overrun_count <= '0;
      end else if (clear) begin
         samples       <= '0;
         nch_q         <= '0;
         idx           <= '0;
         overrun       <= 1'b0;
         overrun_count <= '0;
      end else begin
         idx <= busy ? idx + IDX_BITS'(1) : '0;
         if (accept) begin
            samples <= sample_bus;
            nch_q   <= nch_in;
         end
         if (drop) begin
            overrun       <= 1'b1;
            overrun_count <= (overrun_count == OVR_CNT_MAX) ? overrun_count : overrun_count + 16'd1;
         end
      end
   end

`ifdef RX_PACKER_HEADER_EN
   logic [7:0]       seq;
   logic [WIDTH-1:0] header;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         seq    <= '0;
         header <= '0;
      end else if (clear) begin
         seq    <= '0;
         header <= '0;
      end else if (accept) begin
         header <= make_header(seq, overrun, nch_in);
         seq    <= seq + 8'd1;
      end
   end
`endif

   rx_word_sel u_sel (
      .samples (samples),
`ifdef RX_PACKER_HEADER_EN
      .header  (header),
`endif
      .idx     (idx),
      .word    (word)
   );
endmodule

// File: tb/tb_rx_chan_packer.sv
// tb_rx_chan_packer: randomized self-checking bench; a frame-level model predicts words, drops and counters.
// Honours RX_PACKER_HEADER_EN like the design.
module tb_rx_chan_packer;
`ifdef RX_PACKER_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   logic         clock = 1'b0, reset_n = 1'b0, clear = 1'b0, strobe = 1'b0, fifo_wrfull = 1'b0;
   logic [2:0]   channels = '0;
   logic [127:0] sample_bus = '0;
   logic [9:0]   fifo_wrusedw = '0;
   logic [15:0]  fifo_data, overrun_count;
   logic         fifo_wrreq, busy, overrun;

   int          errors = 0, checks = 0;
   logic        m_ovr = 1'b0;
   int          m_cnt = 0, m_seq = 0;
   logic [15:0] exp_q[$], obs_q[$];
   int          obs_first, obs_last, obs_busy;

   rx_chan_packer dut (
      .clock(clock), .reset_n(reset_n), .clear(clear), .channels(channels), .strobe(strobe),
      .sample_bus(sample_bus), .fifo_wrusedw(fifo_wrusedw), .fifo_wrfull(fifo_wrfull),
      .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .busy(busy), .overrun(overrun),
      .overrun_count(overrun_count)
   );

   always #5 clock = ~clock;

   function automatic logic [127:0] rnd_bus();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Frame-level prediction of one strobe seen while the packer is idle.
   task automatic model_strobe(input logic [127:0] bus, input int ch, input int free);
      int n, flen;
      n = (ch > 4) ? 4 : ch;
      flen = 2*n + HDR;
      if (n == 0) return;
      if (free >= flen) begin
         if (HDR != 0) exp_q.push_back({8'(m_seq), m_ovr, 4'b0, 3'(n)});
         for (int k = 0; k < 2*n; k++) exp_q.push_back(bus[k*16 +: 16]);
         m_seq = (m_seq + 1) % 256;
      end else begin
         m_ovr = 1'b1;
         if (m_cnt < 65535) m_cnt++;
      end
   endtask

   task automatic do_frame(input int ch, input logic [127:0] bus, input int usedw, input logic full);
      exp_q.delete(); obs_q.delete();
      obs_first = -1; obs_last = -1; obs_busy = 0;
      @(negedge clock);
      channels = 3'(ch); sample_bus = bus; fifo_wrusedw = 10'(usedw); fifo_wrfull = full; strobe = 1'b1;
      model_strobe(bus, ch, full ? 0 : 1024 - usedw);
      for (int c = 0; c < 11; c++) begin
         @(negedge clock);
         strobe = 1'b0; fifo_wrfull = 1'b0;
         #1;
         if (fifo_wrreq) begin
            obs_q.push_back(fifo_data);
            if (obs_first < 0) obs_first = c;
            obs_last = c;
         end
         if (busy) obs_busy++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      checks++;
      if ({fifo_data, fifo_wrreq, busy, overrun, overrun_count} !== 35'd0)
         $display("FAIL reset_hold: got data=%h wrreq=%b busy=%b ovr=%b cnt=%h want all 0",
                  fifo_data, fifo_wrreq, busy, overrun, overrun_count);
      if ({fifo_data, fifo_wrreq, busy, overrun, overrun_count} !== 35'd0) errors++;
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if ({fifo_data, fifo_wrreq, busy, overrun, overrun_count} !== 35'd0) begin
         errors++;
         $display("FAIL reset_release: got wrreq=%b busy=%b ovr=%b want 0", fifo_wrreq, busy, overrun);
      end
   endtask

   task automatic test_basic();
      logic [15:0] ref_w [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      do_frame(2, {64'h0, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0, 1'b0);
      checks++;
      if (obs_q.size() != 4 + HDR) begin
         errors++;
         $display("FAIL basic_len: got %0d words want %0d", obs_q.size(), 4 + HDR);
      end else
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[HDR+k] !== ref_w[k]) begin
               errors++;
               $display("FAIL basic_word%0d: got %h want %h", k, obs_q[HDR+k], ref_w[k]);
            end
         end
      checks++;
      if (obs_first != 0 || obs_busy != 4 + HDR) begin
         errors++;
         $display("FAIL basic_timing: got first=%0d busy=%0d want 0 and %0d", obs_first, obs_busy, 4 + HDR);
      end
      for (int r = 0; r < 20; r++) begin
         int ch, usedw;
         ch = int'($urandom_range(1, 4));
         usedw = int'($urandom_range(0, 1024 - 2*ch - HDR));
         do_frame(ch, rnd_bus(), usedw, 1'b0);
         checks++;
         if (obs_q.size() != exp_q.size() || obs_first != 0 || obs_busy != exp_q.size()
             || obs_last - obs_first + 1 != obs_q.size()) begin
            errors++;
            $display("FAIL rand_shape%0d: got n=%0d first=%0d busy=%0d want n=%0d first=0", r,
                     obs_q.size(), obs_first, obs_busy, exp_q.size());
         end else
            for (int k = 0; k < exp_q.size(); k++) begin
               checks++;
               if (obs_q[k] !== exp_q[k]) begin
                  errors++;
                  $display("FAIL rand_word%0d.%0d: got %h want %h", r, k, obs_q[k], exp_q[k]);
               end
            end
      end
      checks++;
      if ({overrun, overrun_count} !== {m_ovr, 16'(m_cnt)}) begin
         errors++;
         $display("FAIL basic_ovr: got %b/%0d want %b/%0d", overrun, overrun_count, m_ovr, m_cnt);
      end
   endtask

   task automatic test_free_boundary();
      int usedw [10];
      int chs [10];
      logic fulls [10];
      usedw[0] = 1017; chs[0] = 4; fulls[0] = 1'b0;
      usedw[1] = 1016; chs[1] = 4; fulls[1] = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         chs[2*n] = n; chs[2*n+1] = n; fulls[2*n] = 1'b0; fulls[2*n+1] = 1'b0;
         usedw[2*n]   = 1024 - (2*n + HDR) + 1;
         usedw[2*n+1] = 1024 - (2*n + HDR);
      end
      usedw[9] = 0; chs[9] = 2; fulls[9] = 1'b1;
      for (int t = 0; t < 10; t++) begin
         do_frame(chs[t], rnd_bus(), usedw[t], fulls[t]);
         checks++;
         if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL free%0d_len: got %0d words want %0d (usedw=%0d)", t, obs_q.size(), exp_q.size(),
                     usedw[t]);
         end else
            for (int k = 0; k < exp_q.size(); k++) begin
               checks++;
               if (obs_q[k] !== exp_q[k]) begin
                  errors++;
                  $display("FAIL free%0d_word%0d: got %h want %h", t, k, obs_q[k], exp_q[k]);
               end
            end
         checks++;
         if ({overrun, overrun_count} !== {m_ovr, 16'(m_cnt)}) begin
            errors++;
            $display("FAIL free%0d_ovr: got %b/%0d want %b/%0d", t, overrun, overrun_count, m_ovr, m_cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      int flen, gap;
      logic [127:0] b1, b2;
      flen = 2 + HDR;
      for (int s = 0; s < 2; s++) begin
         gap = (s != 0) ? flen + 1 : 2;
         b1 = rnd_bus(); b2 = rnd_bus();
         exp_q.delete(); obs_q.delete();
         model_strobe(b1, 1, 1024);
         if (s != 0) model_strobe(b2, 1, 1024);
         else begin
            m_ovr = 1'b1;
            if (m_cnt < 65535) m_cnt++;
         end
         for (int c = 0; c < 2*flen + 6; c++) begin
            @(negedge clock);
            channels = 3'd1; fifo_wrusedw = '0;
            strobe = (c == 0 || c == gap);
            sample_bus = (c == gap) ? b2 : b1;
            #1;
            if (fifo_wrreq) obs_q.push_back(fifo_data);
         end
         strobe = 1'b0;
         checks++;
         if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b%0d_len: got %0d words want %0d", s, obs_q.size(), exp_q.size());
         end else
            for (int k = 0; k < exp_q.size(); k++) begin
               checks++;
               if (obs_q[k] !== exp_q[k]) begin
                  errors++;
                  $display("FAIL b2b%0d_word%0d: got %h want %h", s, k, obs_q[k], exp_q[k]);
               end
            end
         checks++;
         if ({overrun, overrun_count} !== {m_ovr, 16'(m_cnt)}) begin
            errors++;
            $display("FAIL b2b%0d_ovr: got %b/%0d want %b/%0d", s, overrun, overrun_count, m_ovr, m_cnt);
         end
      end
   endtask

   task automatic test_wrfull_abort();
      logic [127:0] b;
      b = rnd_bus();
      exp_q.delete(); obs_q.delete();
      @(negedge clock);
      channels = 3'd2; sample_bus = b; fifo_wrusedw = '0; strobe = 1'b1;
      model_strobe(b, 2, 1024);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         strobe = 1'b0; fifo_wrfull = (c == 3);
         #1;
         if (fifo_wrreq) obs_q.push_back(fifo_data);
         if (c == 4) begin
            checks++;
            if (busy !== 1'b0 || fifo_wrreq !== 1'b0) begin
               errors++;
               $display("FAIL abort_idle: got busy=%b wrreq=%b want 0", busy, fifo_wrreq);
            end
         end
      end
      m_ovr = 1'b1;
      if (m_cnt < 65535) m_cnt++;
      checks++;
      if (obs_q.size() != 2) begin
         errors++;
         $display("FAIL abort_len: got %0d pulses want 2", obs_q.size());
      end else
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
               errors++;
               $display("FAIL abort_word%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
         end
      checks++;
      if ({overrun, overrun_count} !== {m_ovr, 16'(m_cnt)}) begin
         errors++;
         $display("FAIL abort_ovr: got %b/%0d want %b/%0d", overrun, overrun_count, m_ovr, m_cnt);
      end
   endtask

   task automatic test_nch_edge();
      int chs [2] = '{0, 7};
      for (int t = 0; t < 2; t++) begin
         do_frame(chs[t], rnd_bus(), 0, 1'b0);
         checks++;
         if (obs_q.size() != exp_q.size() || obs_busy != exp_q.size()) begin
            errors++;
            $display("FAIL nch%0d_len: got %0d words busy=%0d want %0d", chs[t], obs_q.size(), obs_busy,
                     exp_q.size());
         end else
            for (int k = 0; k < exp_q.size(); k++) begin
               checks++;
               if (obs_q[k] !== exp_q[k]) begin
                  errors++;
                  $display("FAIL nch%0d_word%0d: got %h want %h", chs[t], k, obs_q[k], exp_q[k]);
               end
            end
         checks++;
         if ({overrun, overrun_count} !== {m_ovr, 16'(m_cnt)}) begin
            errors++;
            $display("FAIL nch%0d_ovr: got %b/%0d want %b/%0d", chs[t], overrun, overrun_count, m_ovr, m_cnt);
         end
      end
   endtask

   task automatic test_clear();
      do_frame(4, rnd_bus(), 1023, 1'b0);
      @(negedge clock);
      channels = 3'd2; sample_bus = rnd_bus(); fifo_wrusedw = '0; strobe = 1'b1; clear = 1'b1;
      @(negedge clock);
      strobe = 1'b0; clear = 1'b0;
      #1;
      m_ovr = 1'b0; m_cnt = 0; m_seq = 0;
      checks++;
      if ({busy, fifo_wrreq, overrun, overrun_count} !== 19'd0) begin
         errors++;
         $display("FAIL clear_strobe: got busy=%b wrreq=%b ovr=%b cnt=%0d want 0", busy, fifo_wrreq, overrun,
                  overrun_count);
      end
      @(negedge clock);
      channels = 3'd4; strobe = 1'b1;
      @(negedge clock);
      strobe = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      #1;
      m_seq = 0;
      checks++;
      if (busy !== 1'b0 || fifo_wrreq !== 1'b0) begin
         errors++;
         $display("FAIL clear_midframe: got busy=%b wrreq=%b want 0", busy, fifo_wrreq);
      end
   endtask

   task automatic test_async_reset();
      do_frame(4, rnd_bus(), 1023, 1'b0);
      @(negedge clock);
      channels = 3'd4; sample_bus = rnd_bus(); fifo_wrusedw = '0; strobe = 1'b1;
      @(negedge clock);
      strobe = 1'b0;
      @(negedge clock);
      #2;
      checks++;
      if (busy !== 1'b1 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: got busy=%b ovr=%b want 1", busy, overrun);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({fifo_data, fifo_wrreq, busy, overrun, overrun_count} !== 35'd0) begin
         errors++;
         $display("FAIL async_reset: got data=%h wrreq=%b busy=%b ovr=%b cnt=%h want all 0", fifo_data,
                  fifo_wrreq, busy, overrun, overrun_count);
      end
      @(negedge clock);
      reset_n = 1'b1;
      m_ovr = 1'b0; m_cnt = 0; m_seq = 0;
   endtask

`ifdef RX_PACKER_HEADER_EN
   task automatic test_header();
      logic [15:0] hdr_w [3] = '{16'h0001, 16'h0101, 16'h0201};
      for (int f = 0; f < 3; f++) begin
         do_frame(1, rnd_bus(), 0, 1'b0);
         checks++;
         if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL hdr%0d_len: got %0d words want 3", f, obs_q.size());
         end else begin
            checks++;
            if (obs_q[0] !== hdr_w[f]) begin
               errors++;
               $display("FAIL hdr%0d_word: got %h want %h", f, obs_q[0], hdr_w[f]);
            end
            for (int k = 1; k < 3; k++) begin
               checks++;
               if (obs_q[k] !== exp_q[k]) begin
                  errors++;
                  $display("FAIL hdr%0d_sample%0d: got %h want %h", f, k, obs_q[k], exp_q[k]);
               end
            end
         end
      end
   endtask
`endif

   task automatic test_saturation();
      int k;
      k = 65534 - m_cnt;
      @(negedge clock);
      channels = 3'd4; fifo_wrusedw = '0; fifo_wrfull = 1'b1; strobe = 1'b1;
      repeat (k) @(negedge clock);
      strobe = 1'b0;
      #1;
      m_ovr = 1'b1; m_cnt = 65534;
      checks++;
      if (overrun_count !== 16'(m_cnt)) begin
         errors++;
         $display("FAIL sat_pre: got %h want %h", overrun_count, 16'(m_cnt));
      end
      @(negedge clock);
      strobe = 1'b1;
      repeat (3) @(negedge clock);
      strobe = 1'b0; fifo_wrfull = 1'b0;
      #1;
      m_cnt = 65535;
      checks++;
      if ({overrun, overrun_count} !== {m_ovr, 16'(m_cnt)}) begin
         errors++;
         $display("FAIL sat_hold: got %b/%h want %b/%h", overrun, overrun_count, m_ovr, 16'(m_cnt));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_free_boundary();
      test_back_to_back();
      test_wrfull_abort();
      test_nch_edge();
      test_clear();
      test_async_reset();
`ifdef RX_PACKER_HEADER_EN
      test_header();
`endif
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
